// File: rtl/dispatch_rr_arbiter.sv
// dispatch_rr_arbiter: round-robin arbiter in front of a 2-entry registered
// elastic buffer. Shares one execution-unit dispatch port between NUM_REQS
// issue slices. Payloads pass through unmodified.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high on the same channel. On the input side valid_in[i] must hold (with
// stable data_in[i]) until ready_in[i] is seen. ready_in is at most one-hot and
// depends only on valid_in and registered state. On the output side valid_out
// and data_out/sel_out are registered and hold stable while ready_out is low.
module dispatch_rr_arbiter #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 512,
  parameter int PERF_W     = 32,
  parameter int SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  valid_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]  data_in,
  output logic [NUM_REQS-1:0]                  ready_in,
  output logic                                 valid_out,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic [SEL_W-1:0]                     sel_out,
  input  logic                                 ready_out,
  output logic [PERF_W-1:0]                    perf_stalls
);

  // Two-entry buffer of {data, sel} with 1-bit head/tail pointers.
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [SEL_W-1:0]      buf_sel  [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            count;
  logic [SEL_W-1:0]      ptr;

  logic                  can_accept;
  logic                  any_valid;
  logic                  found;
  logic [SEL_W-1:0]      grant;
  logic [SEL_W-1:0]      ptr_next;
  logic                  push;
  logic                  pop;

  assign can_accept = (count != 2'd2);
  assign any_valid  = |valid_in;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    int              idx;
    logic [SEL_W-1:0] idx_sel;
    found   = 1'b0;
    grant   = '0;
    idx     = 0;
    idx_sel = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx     = (int'(ptr) + k) % NUM_REQS;
      idx_sel = SEL_W'(idx);
      if (!found && valid_in[idx_sel]) begin
        found = 1'b1;
        grant = idx_sel;
      end
    end
  end

  // Priority moves to the requester just after the one granted.
  assign ptr_next = (int'(grant) == NUM_REQS - 1) ? '0 : grant + 1'b1;

  // Reset gating keeps ready_in low for the whole time reset is asserted.
  assign push = reset && found && can_accept;
  assign pop  = valid_out && ready_out;

  // One-hot ready to the granted requester when the buffer has room.
  always_comb begin
    ready_in = '0;
    if (push) ready_in[grant] = 1'b1;
  end

  assign valid_out = (count != 2'd0);
  assign data_out  = buf_data[head];
  assign sel_out   = buf_sel[head];

  // Buffer storage, pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_sel[0]  <= '0;
      buf_sel[1]  <= '0;
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      ptr         <= '0;
    end else begin
      if (push) begin
        buf_data[tail] <= data_in[grant];
        buf_sel[tail]  <= grant;
        tail           <= ~tail;
        ptr            <= ptr_next;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of cycles where someone wants in but the buffer is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stalls <= '0;
    end else if (any_valid && !can_accept && (perf_stalls != '1)) begin
      perf_stalls <= perf_stalls + 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_rr_arbiter.sv
// Self-checking bench for dispatch_rr_arbiter: directed scenarios plus a long
// randomized run, all checked against a queue-based reference model.
module tb_dispatch_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PW = 4;
  localparam int SW = 2;

  // ---------------- clock / reset ----------------
  logic                 clk;
  logic                 reset;
  logic [N-1:0]         valid_in;
  logic [N-1:0][DW-1:0] data_in;
  logic [N-1:0]         ready_in;
  logic                 valid_out;
  logic [DW-1:0]        data_out;
  logic [SW-1:0]        sel_out;
  logic                 ready_out;
  logic [PW-1:0]        perf_stalls;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dispatch_rr_arbiter #(
    .NUM_REQS  (N),
    .DATA_WIDTH(DW),
    .PERF_W    (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .sel_out    (sel_out),
    .ready_out  (ready_out),
    .perf_stalls(perf_stalls)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds accepted {sel, data} in acceptance order; its size is the
  // buffer occupancy the design should have.
  logic [SW+DW-1:0] exp_q[$];
  int ptr_m;
  int stalls_m;
  int last_grant;
  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ptr_m      = 0;
    stalls_m   = 0;
    last_grant = -1;
  endtask

  // One clock: check outputs against the model at negedge, advance the model,
  // then return just after the next posedge so the caller can drive inputs.
  task automatic cycle();
    int               g;
    logic [N-1:0]     exp_ready;
    logic [SW+DW-1:0] hd;
    @(negedge clk);
    g = -1;
    if (exp_q.size() < 2) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr_m + k) % N;
        if (g < 0 && valid_in[i]) g = i;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ready_in", ready_in, exp_ready);
    check("valid_out", valid_out, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      hd = exp_q[0];
      check("data_out", data_out, hd[DW-1:0]);
      check("sel_out", sel_out, hd[SW+DW-1:DW]);
    end
    check("perf_stalls", perf_stalls, stalls_m);
    if (|valid_in && exp_q.size() == 2 && stalls_m < (1 << PW) - 1) stalls_m++;
    if (exp_q.size() != 0 && ready_out) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back({SW'(g), data_in[g]});
      ptr_m = (g + 1) % N;
    end
    last_grant = g;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset     = 1'b0;
    valid_in  = '0;
    ready_out = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Requesters keep valid/data until granted; after a grant they pick anew.
  task automatic refresh_random();
    for (int i = 0; i < N; i++) begin
      if (!valid_in[i] || last_grant == i) begin
        valid_in[i] = 1'($urandom_range(0, 1));
        data_in[i]  = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        valid_in[i] = 1'b0;
      end
    end
    ready_out = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] pa, pb, pc;
    int seq [5];
    checks   = 0;
    failures = 0;
    reset     = 1'b0;
    valid_in  = '1;
    data_in   = '0;
    ready_out = 1'b0;
    model_reset();

    // Reset state, with requesters already asserting valid.
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sel_out", sel_out, 0);
    check("rst_ready_in", ready_in, 0);
    check("rst_perf", perf_stalls, 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    valid_in = '0;

    // Round-robin fairness: all valid, ready_out high.
    for (int i = 0; i < N; i++) data_in[i] = $urandom;
    valid_in  = '1;
    ready_out = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        check("rr_valid", valid_out, 1);
        check("rr_sel", sel_out, (k - 1) % N);
      end
      cycle();
      if (last_grant >= 0) data_in[last_grant] = $urandom;
    end

    // Sparse requesters: get ptr to 2 by granting 1, then only 1 and 3.
    do_reset();
    ready_out = 1'b1;
    valid_in  = 4'b0010;
    cycle();
    check("sparse_setup", last_grant, 1);
    valid_in = 4'b1010;
    seq = '{3, 1, 3, 1, 3};
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("sparse_grant", last_grant, seq[k]);
      data_in[last_grant] = $urandom;
    end
    valid_in[0] = 1'b1;
    cycle();
    check("sparse_join0", last_grant, 0);

    // Backpressure with one requester and payloads A, B, C.
    do_reset();
    pa = 32'hA0A0_0001;
    pb = 32'hB0B0_0002;
    pc = 32'hC0C0_0003;
    ready_out  = 1'b0;
    valid_in   = 4'b0100;
    data_in[2] = pa;
    cycle();
    check("bp_accept_a", last_grant, 2);
    data_in[2] = pb;
    cycle();
    check("bp_accept_b", last_grant, 2);
    data_in[2] = pc;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_stall", last_grant, -1);
      check("bp_hold_a", data_out, pa);
    end
    check("bp_perf3", perf_stalls, 3);
    ready_out = 1'b1;
    check("bp_out_a", data_out, pa);
    cycle();
    check("bp_full_nopush", last_grant, -1);
    check("bp_out_b", data_out, pb);
    cycle();
    check("bp_accept_c", last_grant, 2);
    valid_in = '0;
    check("bp_out_c", data_out, pc);
    cycle();
    check("bp_empty", valid_out, 0);

    // Stall counter saturation at 2^PW-1.
    do_reset();
    ready_out = 1'b0;
    valid_in  = 4'b0001;
    for (int k = 0; k < 22; k++) begin
      cycle();
      if (last_grant >= 0) data_in[0] = $urandom;
    end
    check("perf_sat", perf_stalls, 15);

    // Reset mid-traffic: buffer full, reset pulled low between edges.
    check("mid_full", valid_out, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid_out", valid_out, 0);
    check("mid_data_out", data_out, 0);
    check("mid_sel_out", sel_out, 0);
    check("mid_ready_in", ready_in, 0);
    check("mid_perf", perf_stalls, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    valid_in  = '1;
    ready_out = 1'b1;
    cycle();
    check("mid_first_grant", last_grant, 0);

    // Long randomized run against the model.
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      refresh_random();
      cycle();
    end
    valid_in  = '0;
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_valid_out", valid_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
